rs232_rx: RTL

RS232_RX -- requirements
Module: RS232_rx

---
 rtl/rs232_rx.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/rs232_rx.sv
// ============================================================================
// Module   : rs232_rx
// Purpose  : 8N1 RS-232 receiver with a 2-flop synchronizer and mid-bit sampling
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rs232_rx #(
   parameter int BAUD_CYCLES = 434,
   parameter int HALF_CYCLES = 217
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] dataOut,
   output logic       dataDoneFlag,
   output logic       frameErr,
   output logic       busy
);

   localparam int C_CNT_MAX = (BAUD_CYCLES > HALF_CYCLES) ? BAUD_CYCLES : HALF_CYCLES;
   localparam int C_CNT_W   = (C_CNT_MAX > 1) ? $clog2(C_CNT_MAX) : 1;
   localparam logic [C_CNT_W-1:0] C_BAUD_LAST = C_CNT_W'(BAUD_CYCLES - 1);
   localparam logic [C_CNT_W-1:0] C_HALF_LAST = C_CNT_W'(HALF_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   state_t               r_state;
   state_t               w_state_next;
   logic                 r_sync1;
   logic                 r_rxs;
   logic                 r_rxPrev;
   logic [1:0]           r_live;
   logic                 r_armed;
   logic                 w_armed_next;
   logic                 w_fall;
   logic [C_CNT_W-1:0]   r_cnt;
   logic [C_CNT_W-1:0]   w_cnt_next;
   logic [2:0]           r_idx;
   logic [2:0]           w_idx_next;
   logic [7:0]           r_shift;
   logic [7:0]           w_shift_next;
   logic [7:0]           r_dataOut;
   logic [7:0]           w_data_next;
   logic                 r_done;
   logic                 w_done_next;
   logic                 r_ferr;
   logic                 w_ferr_next;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_sync1   <= 1'b1;
         r_rxs     <= 1'b1;
         r_rxPrev  <= 1'b1;
         r_live    <= 2'b00;
         r_armed   <= 1'b0;
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_idx     <= 3'd0;
         r_shift   <= 8'h00;
         r_dataOut <= 8'h00;
         r_done    <= 1'b0;
         r_ferr    <= 1'b0;
      end else begin
         r_sync1   <= rx;
         r_rxs     <= r_sync1;
         r_rxPrev  <= r_rxs;
         r_live    <= {r_live[0], 1'b1};
         r_armed   <= w_armed_next;
         r_state   <= w_state_next;
         r_cnt     <= w_cnt_next;
         r_idx     <= w_idx_next;
         r_shift   <= w_shift_next;
         r_dataOut <= w_data_next;
         r_done    <= w_done_next;
         r_ferr    <= w_ferr_next;
      end
   end

   // The synchronizer resets to 1, so a line held low through reset would look
   // like a falling edge; only a genuinely sampled high arms edge detection.
   assign w_armed_next = r_armed | (r_live[1] & r_rxs);
   assign w_fall       = r_armed & r_rxPrev & ~r_rxs;

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_idx_next   = r_idx;
      w_shift_next = r_shift;
      w_data_next  = r_dataOut;
      w_done_next  = 1'b0;
      w_ferr_next  = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_cnt_next = '0;
            w_idx_next = 3'd0;
            if (w_fall) begin
               w_state_next = S_START;
            end
         end
         S_START: begin
            if (r_cnt == C_HALF_LAST) begin
               w_cnt_next   = '0;
               w_state_next = r_rxs ? S_IDLE : S_DATA;
            end else begin
               w_cnt_next = r_cnt + 1'b1;
            end
         end
         S_DATA: begin
            if (r_cnt == C_BAUD_LAST) begin
               w_cnt_next          = '0;
               w_shift_next[r_idx] = r_rxs;
               if (r_idx == 3'd7) begin
                  w_state_next = S_STOP;
               end else begin
                  w_idx_next = r_idx + 3'd1;
               end
            end else begin
               w_cnt_next = r_cnt + 1'b1;
            end
         end
         S_STOP: begin
            if (r_cnt == C_BAUD_LAST) begin
               w_cnt_next   = '0;
               w_state_next = S_IDLE;
               if (r_rxs) begin
                  w_data_next = r_shift;
                  w_done_next = 1'b1;
               end else begin
                  w_ferr_next = 1'b1;
               end
            end else begin
               w_cnt_next = r_cnt + 1'b1;
            end
         end
         default: begin
            w_state_next = S_IDLE;
            w_cnt_next   = '0;
            w_idx_next   = 3'd0;
         end
      endcase
   end

   assign dataOut      = r_dataOut;
   assign dataDoneFlag = r_done;
   assign frameErr     = r_ferr;
   assign busy         = (r_state != S_IDLE);

endmodule

`default_nettype wire
